instr_fetch_mem: RTL and testbench

- Instruction memory for the IF stage, directly downstream of the program counter register.
- Accepts the current PC each cycle and returns the addressed 32-bit instruction through a registered read port.
- A byte-serial load port, driven by the debug/UART unit, assembles bytes into words and writes them sequentially.
- Loading ends on a HALT word or when memory is full; fetch is gated until loading is complete.

---
 rtl/instr_fetch_mem.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_mem.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_mem.sv
// Instruction memory for the IF stage.
// A byte-serial load port assembles big-endian words and writes them in
// order until a HALT word arrives or the memory is full. Once loaded, the
// PC fetches one word per enabled cycle through a registered read port.
module instr_fetch_mem #(
  parameter int unsigned      NB_DATA   = 32,
  parameter int unsigned      NB_ADDR   = 8,
  parameter int unsigned      NB_BYTE   = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load_valid,
  input  logic [NB_BYTE-1:0] i_load_byte,
  output logic               o_load_ready,
  input  logic               i_load_clear,
  input  logic               i_fetch_en,
  input  logic [NB_DATA-1:0] i_PC,
  output logic [NB_DATA-1:0] o_instr,
  output logic               o_instr_valid,
  output logic               o_misaligned,
  output logic               o_prog_loaded,
  output logic [NB_ADDR:0]   o_word_count
);

  localparam int unsigned      DEPTH      = 1 << NB_ADDR;
  localparam logic [NB_ADDR:0] FULL_COUNT = {1'b1, {NB_ADDR{1'b0}}};

  typedef enum logic {ST_LOADING, ST_LOADED} state_t;
  // What o_instr shows: zero (reset / misaligned NOP), RAM data, or HALT.
  typedef enum logic [1:0] {SEL_ZERO, SEL_RAM, SEL_HALT} sel_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [1:0]           r_byte_cnt;
  logic [NB_DATA-1:0]   r_asm;
  logic [NB_ADDR:0]     r_word_count;
  logic [NB_DATA-1:0]   r_mem [DEPTH];
  logic [NB_DATA-1:0]   r_ram_q;
  sel_t                 r_sel;
  logic                 r_valid;
  logic                 r_mis;

  logic                 w_accept;
  logic                 w_write;
  logic [NB_DATA-1:0]   w_word;
  logic [NB_ADDR:0]     w_count_inc;
  logic [NB_ADDR-1:0]   w_wr_ptr;
  logic [NB_ADDR-1:0]   w_rd_idx;
  logic                 w_fetch;
  logic                 w_pc_mis;
  logic                 w_beyond;

  // Clear takes priority, so a byte arriving with it is dropped.
  assign w_accept    = i_load_valid & o_load_ready & ~i_load_clear;
  assign w_word      = {r_asm[NB_DATA-NB_BYTE-1:0], i_load_byte};
  assign w_write     = w_accept & (r_byte_cnt == 2'd3);
  assign w_count_inc = r_word_count + 1'b1;
  // Words are written strictly in order, so the count doubles as pointer.
  assign w_wr_ptr    = r_word_count[NB_ADDR-1:0];

  // Fetch only from a fully loaded program; higher PC bits wrap around.
  assign w_fetch  = o_prog_loaded & i_fetch_en & ~i_load_clear;
  assign w_rd_idx = i_PC[NB_ADDR+1:2];
  assign w_pc_mis = (i_PC[1:0] != 2'b00);
  assign w_beyond = ({1'b0, w_rd_idx} >= r_word_count);

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_LOADING;
    else         r_state <= w_state_next;
  end

  // Next state: leave LOADING on a HALT word or when the last slot fills.
  always_comb begin
    w_state_next = r_state;
    if (i_load_clear) begin
      w_state_next = ST_LOADING;
    end else if (r_state == ST_LOADING && w_write &&
                 (w_word == HALT_WORD || w_count_inc == FULL_COUNT)) begin
      w_state_next = ST_LOADED;
    end
  end

  // State-derived outputs; ready is held low while reset is asserted.
  always_comb begin
    o_prog_loaded = (r_state == ST_LOADED);
    o_load_ready  = (r_state == ST_LOADING) && (r_word_count != FULL_COUNT) && !i_reset;
  end

  // Byte assembly and word counting.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_byte_cnt   <= 2'd0;
      r_asm        <= '0;
      r_word_count <= '0;
    end else if (i_load_clear) begin
      r_byte_cnt   <= 2'd0;
      r_asm        <= '0;
      r_word_count <= '0;
    end else if (w_accept) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
      r_asm      <= w_word;
      if (w_write) r_word_count <= w_count_inc;
    end
  end

  // Block RAM: synchronous write during load, registered read on fetch.
  always_ff @(posedge i_clk) begin
    if (w_write) r_mem[w_wr_ptr] <= w_word;
    if (w_fetch) r_ram_q <= r_mem[w_rd_idx];
  end

  // Fetch status: which value to present, validity and misalignment.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sel   <= SEL_ZERO;
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
    end else if (i_load_clear) begin
      r_valid <= 1'b0;
    end else if (w_fetch) begin
      r_valid <= 1'b1;
      r_mis   <= w_pc_mis;
      if (w_pc_mis)      r_sel <= SEL_ZERO;
      else if (w_beyond) r_sel <= SEL_HALT;
      else               r_sel <= SEL_RAM;
    end else if (!o_prog_loaded) begin
      r_valid <= 1'b0;
    end
  end

  // Instruction mux; HALT past the loaded program hides stale RAM.
  always_comb begin
    case (r_sel)
      SEL_RAM:  o_instr = r_ram_q;
      SEL_HALT: o_instr = HALT_WORD;
      default:  o_instr = '0;
    endcase
  end

  assign o_instr_valid = r_valid;
  assign o_misaligned  = r_mis;
  assign o_word_count  = r_word_count;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Testbench for instr_fetch_mem: directed program loads plus randomized
// load/clear/fetch traffic, checked every cycle against a queue-based model.
module tb_instr_fetch_mem;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'h00;
  logic        load_clear = 1'b0;
  logic        fetch_en = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        load_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misaligned;
  logic        prog_loaded;
  logic [8:0]  word_count;

  int tests = 0;
  int fails = 0;

  instr_fetch_mem dut (
    .i_clk(clk), .i_reset(rst),
    .i_load_valid(load_valid), .i_load_byte(load_byte), .o_load_ready(load_ready),
    .i_load_clear(load_clear), .i_fetch_en(fetch_en), .i_PC(pc),
    .o_instr(instr), .o_instr_valid(instr_valid), .o_misaligned(misaligned),
    .o_prog_loaded(prog_loaded), .o_word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [256];
  logic [7:0]  m_q [$];
  int          m_count = 0;
  bit          m_loaded = 0;
  logic [31:0] m_instr = 32'h0;
  bit          m_valid = 0;
  bit          m_mis = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete(); m_count = 0; m_loaded = 0;
      m_instr = 0; m_valid = 0; m_mis = 0;
    end else if (load_clear) begin
      m_q.delete(); m_count = 0; m_loaded = 0; m_valid = 0;
    end else begin
      if (m_loaded && fetch_en) begin
        int idx;
        idx = (pc / 4) % 256;
        m_valid = 1;
        m_mis = (pc % 4) != 0;
        if (m_mis)              m_instr = 0;
        else if (idx >= m_count) m_instr = HALT;
        else                    m_instr = m_mem[idx];
      end else if (!m_loaded) begin
        m_valid = 0;
      end
      if (!m_loaded && m_count < 256 && load_valid) begin
        m_q.push_back(load_byte);
        if (m_q.size() == 4) begin
          logic [31:0] w;
          w = {m_q[0], m_q[1], m_q[2], m_q[3]};
          m_mem[m_count] = w;
          m_count++;
          m_q.delete();
          if (w == HALT || m_count == 256) m_loaded = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("instr", instr, m_instr);
      chk("instr_valid", instr_valid, m_valid);
      chk("misaligned", misaligned, m_mis);
      chk("prog_loaded", prog_loaded, m_loaded);
      chk("word_count", word_count, m_count);
      chk("load_ready", load_ready, !m_loaded && m_count < 256);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b);
    load_valid = 1'b1; load_byte = b;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
  endtask

  task automatic clear_pulse();
    load_clear = 1'b1;
    @(negedge clk);
    load_clear = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_en = 1'b1; pc = a;
    @(negedge clk);
    fetch_en = 1'b0;
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_instr", instr, 32'h0);
    chk("async_rst_valid", instr_valid, 1'b0);
    chk("async_rst_mis", misaligned, 1'b0);
    chk("async_rst_loaded", prog_loaded, 1'b0);
    chk("async_rst_count", word_count, 9'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] prog0 [4];

  initial begin
    prog0[0] = 32'h2008_0005; prog0[1] = 32'h8C09_0004;
    prog0[2] = 32'hFFFF_FFFF; prog0[3] = 32'hFFFF_FFFF;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_instr", instr, 32'h0);
    chk("rst_count", word_count, 9'd0);
    chk("rst_loaded", prog_loaded, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", load_ready, 1'b1);
    chk("post_rst_count", word_count, 9'd0);
    @(negedge clk);

    // Small program ending in HALT.
    send_word(32'h2008_0005);
    send_word(32'h8C09_0004);
    send_word(HALT);
    chk("prog_count", word_count, 9'd3);
    chk("prog_loaded", prog_loaded, 1'b1);
    chk("prog_ready", load_ready, 1'b0);

    // Fetch PC 0,4,8,12 back to back.
    for (int k = 0; k < 4; k++) begin
      fetch_en = 1'b1; pc = 32'(k * 4);
      @(negedge clk);
      chk($sformatf("fetch_pc%0d", k * 4), instr, prog0[k]);
      chk("fetch_valid", instr_valid, 1'b1);
    end

    // Stall with a moving PC.
    fetch_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pc = $urandom;
      @(negedge clk);
      chk("stall_instr", instr, HALT);
    end

    fetch(32'h6);
    chk("misaligned_instr", instr, 32'h0);
    chk("misaligned_flag", misaligned, 1'b1);
    fetch(32'h404);
    chk("wrap_pc404", instr, 32'h8C09_0004);
    chk("wrap_mis", misaligned, 1'b0);

    // Fill the whole memory with non-HALT words.
    clear_pulse();
    for (int w = 0; w < 256; w++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send_word({1'b0, 31'($urandom)});
    end
    chk("fill_count", word_count, 9'd256);
    chk("fill_loaded", prog_loaded, 1'b1);
    chk("fill_ready", load_ready, 1'b0);
    send(8'hA5);
    chk("fill_extra_ignored", word_count, 9'd256);

    // Random fetches over the full memory.
    for (int k = 0; k < 300; k++) begin
      fetch_en = $urandom_range(0, 1);
      pc = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      @(negedge clk);
    end
    fetch_en = 1'b0;

    // Clear wins over a simultaneous byte.
    clear_pulse();
    send(8'h12); send(8'h34);
    load_clear = 1'b1; load_valid = 1'b1; load_byte = 8'h56;
    @(negedge clk);
    load_clear = 1'b0; load_valid = 1'b0;
    chk("clear_count", word_count, 9'd0);
    chk("clear_loaded", prog_loaded, 1'b0);
    send_word(32'h0000_0000);
    send_word(HALT);
    chk("zero_halt_count", word_count, 9'd2);
    fetch(32'h0);
    chk("zero_word", instr, 32'h0);
    fetch(32'h4);
    chk("halt_word", instr, HALT);

    // Reset while loaded, then reset mid-word.
    mid_reset();
    send(8'hDE); send(8'hAD); send(8'hBE);
    mid_reset();
    send_word(32'h1122_3344);
    send_word(HALT);
    chk("after_rst_count", word_count, 9'd2);
    fetch(32'h0);
    chk("after_rst_word0", instr, 32'h1122_3344);

    // Randomized load/clear/fetch traffic.
    for (int k = 0; k < 3000; k++) begin
      load_valid = ($urandom_range(0, 9) < 7);
      load_byte  = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      load_clear = ($urandom_range(0, 149) == 0);
      fetch_en   = $urandom_range(0, 1);
      pc         = $urandom & 32'h0000_07FF;
      @(negedge clk);
    end
    load_valid = 1'b0; load_clear = 1'b0; fetch_en = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
